alu_operand_loader: RTL

//  Input-side counterpart of the ALU result display path. The display path

---
 rtl/alu_operand_loader.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_operand_loader.sv
// Assembles 32-bit operands A and B plus a 3-bit ALU_OP from 8 switches.
// Each debounced press of the enter button loads one byte.
module alu_operand_loader #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  SW,
    input  logic        BTN,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  ALU_OP,
    output logic [1:0]  STAGE,
    output logic [1:0]  BYTE_IDX,
    output logic        VALID
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        DONE    = 2'b11
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             s1, s2, db, db_d;
    logic [CNT_W-1:0] cnt;
    logic             enter;

    stage_t      stage, stage_nxt;
    logic [1:0]  idx_nxt;
    logic [31:0] a_nxt, b_nxt;
    logic [2:0]  op_nxt;
    logic        valid_nxt;

    // db only follows s2 after it has differed for DB_CYCLES consecutive clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            db   <= 1'b0;
            db_d <= 1'b0;
            cnt  <= '0;
        end else begin
            s1   <= BTN;
            s2   <= s1;
            db_d <= db;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign enter = db & ~db_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage    <= LOAD_A;
            BYTE_IDX <= '0;
            A        <= '0;
            B        <= '0;
            ALU_OP   <= '0;
            VALID    <= 1'b0;
        end else begin
            stage    <= stage_nxt;
            BYTE_IDX <= idx_nxt;
            A        <= a_nxt;
            B        <= b_nxt;
            ALU_OP   <= op_nxt;
            VALID    <= valid_nxt;
        end
    end

    always_comb begin
        stage_nxt = stage;
        idx_nxt   = BYTE_IDX;
        a_nxt     = A;
        b_nxt     = B;
        op_nxt    = ALU_OP;
        valid_nxt = VALID;
        if (enter) begin
            unique case (stage)
                LOAD_A: begin
                    a_nxt[{BYTE_IDX, 3'b000} +: 8] = SW;
                    idx_nxt = BYTE_IDX + 2'd1;
                    if (BYTE_IDX == 2'd3) stage_nxt = LOAD_B;
                end
                LOAD_B: begin
                    b_nxt[{BYTE_IDX, 3'b000} +: 8] = SW;
                    idx_nxt = BYTE_IDX + 2'd1;
                    if (BYTE_IDX == 2'd3) stage_nxt = LOAD_OP;
                end
                LOAD_OP: begin
                    op_nxt    = SW[2:0];
                    stage_nxt = DONE;
                    valid_nxt = 1'b1;
                end
                DONE: begin
                    stage_nxt = LOAD_A;
                    idx_nxt   = '0;
                    valid_nxt = 1'b0;
                end
                default: stage_nxt = LOAD_A;
            endcase
        end
    end

    assign STAGE = stage;

endmodule
